// File: rtl/inst_queue_ctrl_pkg.sv
// Shared entry layout and slot PC helpers for the instruction queue.
// An entry is {pc[31:3], inst[63:0], mask[1:0]} packed MSB to LSB.
package inst_queue_ctrl_pkg;

    localparam int IQ_PC_HI_W  = 29;
    localparam int IQ_INST_W   = 64;
    localparam int IQ_MASK_W   = 2;

    localparam int IQ_MASK_LSB = 0;
    localparam int IQ_INST_LSB = IQ_MASK_LSB + IQ_MASK_W;
    localparam int IQ_PC_LSB   = IQ_INST_LSB + IQ_INST_W;
    localparam int IQ_ENTRY_WD = IQ_PC_LSB + IQ_PC_HI_W;

    // Byte offset of slot1 within its 8-byte fetch packet.
    localparam logic [2:0] IQ_SLOT_OFS = 3'd4;

    function automatic logic [31:0] iq_slot_pc(input logic [IQ_PC_HI_W-1:0] pc_hi,
                                               input logic slot);
        return {pc_hi, 3'b000} | {29'd0, (slot ? IQ_SLOT_OFS : 3'd0)};
    endfunction

    function automatic logic [31:0] iq_slot_word(input logic [IQ_INST_W-1:0] inst,
                                                 input logic slot);
        return slot ? inst[63:32] : inst[31:0];
    endfunction

endpackage

// File: rtl/inst_queue_ctrl_if.sv
// Fetch-side, redirect and decoder-side signals of the instruction queue.
// master = fetch/decode environment, slave = the queue itself.
interface inst_queue_ctrl_if;

    logic        br_e;
    logic [31:0] br_addr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic        fetch_ready;
    logic        out0_valid;
    logic [31:0] out0_pc;
    logic [31:0] out0_inst;
    logic        out1_valid;
    logic [31:0] out1_pc;
    logic [31:0] out1_inst;
    logic [1:0]  take;

    modport master (
        output br_e, br_addr, fetch_valid, fetch_pc, fetch_inst, take,
        input  fetch_ready, out0_valid, out0_pc, out0_inst,
               out1_valid, out1_pc, out1_inst
    );

    modport slave (
        input  br_e, br_addr, fetch_valid, fetch_pc, fetch_inst, take,
        output fetch_ready, out0_valid, out0_pc, out0_inst,
               out1_valid, out1_pc, out1_inst
    );

endinterface

// File: rtl/iq_slot_sel.sv
// Picks the two oldest pending instructions from the head entry and the one
// behind it, and reports which slots a given take consumes in each entry.
module iq_slot_sel
    import inst_queue_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic [IQ_ENTRY_WD-1:0] head_ent,
    input  logic [IQ_ENTRY_WD-1:0] nxt_ent,
    input  logic [CNT_W-1:0]       count,
    input  logic [1:0]             take,
    output logic                   out0_valid,
    output logic [31:0]            out0_pc,
    output logic [31:0]            out0_inst,
    output logic                   out1_valid,
    output logic [31:0]            out1_pc,
    output logic [31:0]            out1_inst,
    output logic [1:0]             head_clr,
    output logic [1:0]             nxt_clr
);

    logic [IQ_MASK_W-1:0]  head_mask;
    logic [IQ_MASK_W-1:0]  nxt_mask;
    logic [IQ_PC_HI_W-1:0] head_pc_hi;
    logic [IQ_PC_HI_W-1:0] nxt_pc_hi;
    logic [IQ_INST_W-1:0]  head_inst;
    logic [IQ_INST_W-1:0]  nxt_inst;
    logic                  o0_slot;
    logic                  o1_slot;
    logic                  o1_nxt;

    // Masks outside the occupied range are ignored so stale storage never leaks out.
    assign head_mask  = head_ent[IQ_MASK_LSB +: IQ_MASK_W] & {IQ_MASK_W{count != '0}};
    assign nxt_mask   = nxt_ent[IQ_MASK_LSB +: IQ_MASK_W] & {IQ_MASK_W{count > CNT_W'(1)}};
    assign head_pc_hi = head_ent[IQ_PC_LSB +: IQ_PC_HI_W];
    assign nxt_pc_hi  = nxt_ent[IQ_PC_LSB +: IQ_PC_HI_W];
    assign head_inst  = head_ent[IQ_INST_LSB +: IQ_INST_W];
    assign nxt_inst   = nxt_ent[IQ_INST_LSB +: IQ_INST_W];

    always_comb begin
        out0_valid = |head_mask;
        o0_slot    = ~head_mask[0];
        out1_valid = 1'b0;
        o1_slot    = 1'b1;
        o1_nxt     = 1'b0;
        if (head_mask == 2'b11) begin
            out1_valid = 1'b1;
        end else if (out0_valid && (|nxt_mask)) begin
            out1_valid = 1'b1;
            o1_nxt     = 1'b1;
            o1_slot    = ~nxt_mask[0];
        end

        out0_pc   = '0;
        out0_inst = '0;
        out1_pc   = '0;
        out1_inst = '0;
        if (out0_valid) begin
            out0_pc   = iq_slot_pc(head_pc_hi, o0_slot);
            out0_inst = iq_slot_word(head_inst, o0_slot);
        end
        if (out1_valid) begin
            if (o1_nxt) begin
                out1_pc   = iq_slot_pc(nxt_pc_hi, o1_slot);
                out1_inst = iq_slot_word(nxt_inst, o1_slot);
            end else begin
                out1_pc   = iq_slot_pc(head_pc_hi, o1_slot);
                out1_inst = iq_slot_word(head_inst, o1_slot);
            end
        end

        head_clr = '0;
        nxt_clr  = '0;
        if ((take != 2'd0) && out0_valid) begin
            head_clr[o0_slot] = 1'b1;
        end
        if ((take == 2'd2) && out1_valid) begin
            if (o1_nxt) begin
                nxt_clr[o1_slot] = 1'b1;
            end else begin
                head_clr[o1_slot] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetch and the dual decoders: filters wrong-path
// packets against the expected PC and issues up to two instructions per cycle.
module inst_queue_ctrl
    import inst_queue_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic             clk,
    input  logic             rst,
    inst_queue_ctrl_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W-1:0]      head_nxt;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           exp_pc_q, exp_pc_d;
    logic [IQ_MASK_W-1:0]  mask_q [DEPTH];
    logic [IQ_MASK_W-1:0]  mask_d [DEPTH];
    logic [IQ_PC_HI_W-1:0] pc_hi_q [DEPTH];
    logic [IQ_INST_W-1:0]  inst_q [DEPTH];

    logic [IQ_ENTRY_WD-1:0] head_ent;
    logic [IQ_ENTRY_WD-1:0] nxt_ent;
    logic [1:0]            head_clr;
    logic [1:0]            nxt_clr;
    logic [1:0]            head_left;
    logic [1:0]            nxt_left;
    logic                  pop_head;
    logic                  pop_nxt;
    logic [1:0]            pops;
    logic                  ready;
    logic                  enq_fire;
    logic                  enq_hit;
    logic                  unused_bits;

    assign head_nxt = head_q + 1'b1;
    assign head_ent = {pc_hi_q[head_q], inst_q[head_q], mask_q[head_q]};
    assign nxt_ent  = {pc_hi_q[head_nxt], inst_q[head_nxt], mask_q[head_nxt]};

    assign ready           = (count_q != FULL_CNT);
    assign bus.fetch_ready = ready;
    assign enq_fire        = bus.fetch_valid & ready & ~bus.br_e;
    assign enq_hit         = enq_fire & (bus.fetch_pc[31:3] == exp_pc_q[31:3]);
    assign unused_bits     = ^{bus.fetch_pc[2:0], exp_pc_q[1:0]};

    iq_slot_sel #(
        .CNT_W (CNT_W)
    ) u_slot_sel (
        .head_ent   (head_ent),
        .nxt_ent    (nxt_ent),
        .count      (count_q),
        .take       (bus.take),
        .out0_valid (bus.out0_valid),
        .out0_pc    (bus.out0_pc),
        .out0_inst  (bus.out0_inst),
        .out1_valid (bus.out1_valid),
        .out1_pc    (bus.out1_pc),
        .out1_inst  (bus.out1_inst),
        .head_clr   (head_clr),
        .nxt_clr    (nxt_clr)
    );

    always_comb begin
        mask_d   = mask_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        exp_pc_d = exp_pc_q;

        head_left = mask_q[head_q] & ~head_clr;
        nxt_left  = mask_q[head_nxt] & ~nxt_clr;
        pop_head  = (count_q != '0) && (head_left == 2'b00);
        pop_nxt   = pop_head && (count_q > CNT_W'(1)) && (nxt_left == 2'b00);
        pops      = {1'b0, pop_head} + {1'b0, pop_nxt};

        if (bus.br_e) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_d[i] = '0;
            end
            head_d   = tail_q;
            count_d  = '0;
            exp_pc_d = bus.br_addr;
        end else begin
            mask_d[head_q]   = head_left;
            mask_d[head_nxt] = nxt_left;
            head_d           = head_q + PTR_W'(pops);
            count_d          = count_q + CNT_W'(enq_hit) - CNT_W'(pops);
            // A packet entered mid-packet (after a redirect to slot1) skips slot0.
            if (enq_hit) begin
                mask_d[tail_q] = {1'b1, ~exp_pc_q[2]};
                tail_d         = tail_q + 1'b1;
                exp_pc_d       = {exp_pc_q[31:3] + 29'd1, 3'b000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            exp_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            exp_pc_q <= exp_pc_d;
            mask_q   <= mask_d;
        end
    end

    // Payload storage is only meaningful under a set mask, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq_hit) begin
            pc_hi_q[tail_q] <= bus.fetch_pc[31:3];
            inst_q[tail_q]  <= bus.fetch_inst;
        end
    end

    take_legal_a: assert property (@(posedge clk) disable iff (rst || bus.br_e)
        ({1'b0, bus.take} <= ({2'b00, bus.out0_valid} + {2'b00, bus.out1_valid})));

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Bench for inst_queue_ctrl: directed scenarios plus a randomized take stream,
// all checked against a flat program-order instruction model.
module tb_inst_queue_ctrl;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_queue_ctrl_if bus();

    inst_queue_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending instructions in program order, tagged with packet id.
    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];
    int          m_pkt[$];
    int          m_next_id = 0;
    logic [31:0] m_exp = RESET_PC;

    function automatic int m_count();
        if (m_pc.size() == 0) return 0;
        return m_pkt[m_pkt.size()-1] - m_pkt[0] + 1;
    endfunction

    function automatic int m_avail();
        return (m_pc.size() > 2) ? 2 : m_pc.size();
    endfunction

    // The word stored at address p is ~p, so every instruction is traceable.
    function automatic logic [63:0] mk_pkt(input logic [31:0] pc);
        logic [31:0] b;
        b = {pc[31:3], 3'b000};
        return {~(b + 32'd4), ~b};
    endfunction

    task automatic m_clear();
        m_pc.delete();
        m_inst.delete();
        m_pkt.delete();
    endtask

    task automatic step(input logic fv, input logic [31:0] fpc, input logic [1:0] tk,
                        input logic be, input logic [31:0] baddr);
        logic        ready;
        logic [63:0] finst;
        finst           = mk_pkt(fpc);
        bus.fetch_valid = fv;
        bus.fetch_pc    = fpc;
        bus.fetch_inst  = finst;
        bus.take        = tk;
        bus.br_e        = be;
        bus.br_addr     = baddr;
        @(posedge clk);
        if (rst) begin
            m_clear();
            m_exp = RESET_PC;
        end else if (be) begin
            m_clear();
            m_exp = baddr;
        end else begin
            ready = (m_count() != DEPTH);
            for (int i = 0; i < int'(tk); i++) begin
                if (m_pc.size() > 0) begin
                    void'(m_pc.pop_front());
                    void'(m_inst.pop_front());
                    void'(m_pkt.pop_front());
                end
            end
            if (fv && ready && (fpc[31:3] == m_exp[31:3])) begin
                if (!m_exp[2]) begin
                    m_pc.push_back({fpc[31:3], 3'b000});
                    m_inst.push_back(finst[31:0]);
                    m_pkt.push_back(m_next_id);
                end
                m_pc.push_back({fpc[31:3], 3'b100});
                m_inst.push_back(finst[63:32]);
                m_pkt.push_back(m_next_id);
                m_next_id++;
                m_exp = {m_exp[31:3] + 29'd1, 3'b000};
            end
        end
        @(negedge clk);
        bus.fetch_valid = 1'b0;
        bus.take        = 2'd0;
        bus.br_e        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 32'hbfc0_0000, 2'd0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        rst = 1'b0;
        total++; if (bus.out0_valid !== 1'b0) begin bad++; $display("FAIL reset_out0_valid got=%0b want=0", bus.out0_valid); end
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL reset_out1_valid got=%0b want=0", bus.out1_valid); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_fetch_ready got=%0b want=1", bus.fetch_ready); end
        total++; if ({bus.out0_pc, bus.out0_inst} !== 64'h0) begin bad++; $display("FAIL reset_out0_zero got=%h want=0", {bus.out0_pc, bus.out0_inst}); end
        total++; if ({bus.out1_pc, bus.out1_inst} !== 64'h0) begin bad++; $display("FAIL reset_out1_zero got=%h want=0", {bus.out1_pc, bus.out1_inst}); end
    endtask

    task automatic test_basic();
        step(1'b1, 32'hbfc0_0000, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hbfc0_0008, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0000) begin bad++; $display("FAIL basic_out0_pc got=%h want=bfc00000", bus.out0_pc); end
        total++; if (bus.out0_inst !== ~32'hbfc0_0000) begin bad++; $display("FAIL basic_out0_inst got=%h want=%h", bus.out0_inst, ~32'hbfc0_0000); end
        total++; if (bus.out1_pc !== 32'hbfc0_0004) begin bad++; $display("FAIL basic_out1_pc got=%h want=bfc00004", bus.out1_pc); end
        total++; if (bus.out1_inst !== ~32'hbfc0_0004) begin bad++; $display("FAIL basic_out1_inst got=%h want=%h", bus.out1_inst, ~32'hbfc0_0004); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL basic_fetch_ready got=%0b want=1", bus.fetch_ready); end
    endtask

    task automatic test_full();
        step(1'b1, 32'hbfc0_0010, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hbfc0_0018, 2'd0, 1'b0, 32'h0);
        total++; if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL full_fetch_ready got=%0b want=0", bus.fetch_ready); end
        step(1'b1, 32'hbfc0_0020, 2'd0, 1'b0, 32'h0);
        total++; if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL full_fifth_ready got=%0b want=0", bus.fetch_ready); end
        total++; if (bus.out0_pc !== 32'hbfc0_0000) begin bad++; $display("FAIL full_head_kept got=%h want=bfc00000", bus.out0_pc); end
        step(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL full_drain_ready got=%0b want=1", bus.fetch_ready); end
        total++; if (bus.out0_pc !== 32'hbfc0_0008) begin bad++; $display("FAIL full_drain_out0 got=%h want=bfc00008", bus.out0_pc); end
        total++; if (bus.out1_pc !== 32'hbfc0_000c) begin bad++; $display("FAIL full_drain_out1 got=%h want=bfc0000c", bus.out1_pc); end
    endtask

    task automatic test_flush();
        step(1'b1, 32'hbfc0_0020, 2'd1, 1'b1, 32'hbfc0_0104);
        total++; if (bus.out0_valid !== 1'b0) begin bad++; $display("FAIL flush_out0_valid got=%0b want=0", bus.out0_valid); end
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL flush_out1_valid got=%0b want=0", bus.out1_valid); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL flush_fetch_ready got=%0b want=1", bus.fetch_ready); end
        step(1'b1, 32'hbfc0_0100, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0104) begin bad++; $display("FAIL flush_target_pc got=%h want=bfc00104", bus.out0_pc); end
        total++; if (bus.out0_inst !== ~32'hbfc0_0104) begin bad++; $display("FAIL flush_target_inst got=%h want=%h", bus.out0_inst, ~32'hbfc0_0104); end
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL flush_half_out1 got=%0b want=0", bus.out1_valid); end
        step(1'b1, 32'hbfc0_0040, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL wrongpath_out1 got=%0b want=0", bus.out1_valid); end
        total++; if (bus.out0_pc !== 32'hbfc0_0104) begin bad++; $display("FAIL wrongpath_out0 got=%h want=bfc00104", bus.out0_pc); end
        step(1'b1, 32'hbfc0_0108, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out1_pc !== 32'hbfc0_0108) begin bad++; $display("FAIL flush_next_pc got=%h want=bfc00108", bus.out1_pc); end
    endtask

    task automatic test_cross();
        step(1'b0, 32'h0, 2'd0, 1'b1, 32'hbfc0_0004);
        step(1'b1, 32'hbfc0_0000, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hbfc0_0008, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0004) begin bad++; $display("FAIL cross_out0 got=%h want=bfc00004", bus.out0_pc); end
        total++; if (bus.out1_pc !== 32'hbfc0_0008) begin bad++; $display("FAIL cross_out1 got=%h want=bfc00008", bus.out1_pc); end
        step(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_000c) begin bad++; $display("FAIL cross_after_out0 got=%h want=bfc0000c", bus.out0_pc); end
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL cross_after_out1 got=%0b want=0", bus.out1_valid); end
    endtask

    task automatic test_simul();
        step(1'b0, 32'h0, 2'd0, 1'b1, 32'hbfc0_0000);
        step(1'b1, 32'hbfc0_0000, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hbfc0_0008, 2'd0, 1'b0, 32'h0);
        step(1'b1, 32'hbfc0_0010, 2'd2, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0008) begin bad++; $display("FAIL simul_out0 got=%h want=bfc00008", bus.out0_pc); end
        total++; if (bus.out1_pc !== 32'hbfc0_000c) begin bad++; $display("FAIL simul_out1 got=%h want=bfc0000c", bus.out1_pc); end
        step(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0010) begin bad++; $display("FAIL simul_third_out0 got=%h want=bfc00010", bus.out0_pc); end
        total++; if (bus.out1_pc !== 32'hbfc0_0014) begin bad++; $display("FAIL simul_third_out1 got=%h want=bfc00014", bus.out1_pc); end
        step(1'b1, 32'hbfc0_0018, 2'd1, 1'b1, 32'hbfc0_0018);
        total++; if (bus.out0_valid !== 1'b0) begin bad++; $display("FAIL flush_enq_dropped got=%0b want=0", bus.out0_valid); end
        step(1'b1, 32'hbfc0_0018, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0018) begin bad++; $display("FAIL flush_enq_refetch got=%h want=bfc00018", bus.out0_pc); end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 32'hbfc0_0020, 2'd0, 1'b0, 32'h0);
        rst = 1'b1;
        step(1'b1, 32'hbfc0_0028, 2'd1, 1'b1, 32'hbfc0_0300);
        rst = 1'b0;
        total++; if (bus.out0_valid !== 1'b0) begin bad++; $display("FAIL midrst_out0_valid got=%0b want=0", bus.out0_valid); end
        total++; if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL midrst_fetch_ready got=%0b want=1", bus.fetch_ready); end
        step(1'b1, 32'hbfc0_0000, 2'd0, 1'b0, 32'h0);
        total++; if (bus.out0_pc !== 32'hbfc0_0000) begin bad++; $display("FAIL midrst_exp_pc got=%h want=bfc00000", bus.out0_pc); end
    endtask

    task automatic test_wrap();
        int          n_pkt;
        int          issued;
        int          cycles;
        logic        fv;
        logic [1:0]  tk;
        logic [31:0] obs_pc;
        logic [31:0] obs_inst;
        logic [31:0] want_pc;
        n_pkt  = 0;
        issued = 0;
        cycles = 0;
        step(1'b0, 32'h0, 2'd0, 1'b1, RESET_PC);
        while (issued < 40 && cycles < 400) begin
            total++; if (bus.out0_valid !== (m_avail() > 0)) begin bad++; $display("FAIL wrap_out0_valid cyc=%0d got=%0b want=%0b", cycles, bus.out0_valid, m_avail() > 0); end
            total++; if (bus.out1_valid !== (m_avail() > 1)) begin bad++; $display("FAIL wrap_out1_valid cyc=%0d got=%0b want=%0b", cycles, bus.out1_valid, m_avail() > 1); end
            total++; if (bus.fetch_ready !== (m_count() != DEPTH)) begin bad++; $display("FAIL wrap_fetch_ready cyc=%0d got=%0b want=%0b", cycles, bus.fetch_ready, m_count() != DEPTH); end
            tk = 2'($urandom_range(0, m_avail()));
            for (int k = 0; k < int'(tk); k++) begin
                obs_pc   = (k == 0) ? bus.out0_pc : bus.out1_pc;
                obs_inst = (k == 0) ? bus.out0_inst : bus.out1_inst;
                want_pc  = RESET_PC + 32'(4 * issued);
                total++; if (obs_pc !== want_pc) begin bad++; $display("FAIL wrap_issue_pc n=%0d got=%h want=%h", issued, obs_pc, want_pc); end
                total++; if (obs_inst !== ~want_pc) begin bad++; $display("FAIL wrap_issue_inst n=%0d got=%h want=%h", issued, obs_inst, ~want_pc); end
                issued++;
            end
            fv = (n_pkt < 20);
            if (fv && (m_count() != DEPTH)) begin
                step(1'b1, RESET_PC + 32'(8 * n_pkt), tk, 1'b0, 32'h0);
                n_pkt++;
            end else begin
                step(fv, RESET_PC + 32'(8 * n_pkt), tk, 1'b0, 32'h0);
            end
            cycles++;
        end
        total++; if (issued !== 40) begin bad++; $display("FAIL wrap_issue_count got=%0d want=40", issued); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_inst  = '0;
        bus.take        = 2'd0;
        bus.br_e        = 1'b0;
        bus.br_addr     = '0;
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_cross();
        test_simul();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_queue_ctrl.md
Name: inst_queue_ctrl

Overview:
- Decoupling queue and issue sequencer between instruction fetch and the dual decoders.
- Accepts 64-bit fetch packets (two 32-bit slots) and discards wrong-path packets after a redirect.
- Presents the two oldest valid instructions to the decoder pair each cycle, in program order and across packet boundaries.
- Pops instructions according to how many the scoreboard took that cycle.

Parameters:
- DEPTH, 4, number of 64-bit packet entries (power of 2, ≥2)
- RESET_PC, 32'hbfc0_0000, expected fetch PC after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- br_e  in  1  redirect/flush request
- br_addr  in  32  redirect target PC
- fetch_valid  in  1  packet offered by IF
- fetch_pc  in  32  PC of packet (bits [2:0] ignored except as documented)
- fetch_inst  in  64  slot0 = [31:0], slot1 = [63:32]
- fetch_ready  out  1  queue can accept a packet this cycle
- out0_valid  out  1  oldest instruction valid
- out0_pc  out  32  its PC
- out0_inst  out  32  its word
- out1_valid  out  1  second-oldest instruction valid
- out1_pc  out  32  its PC
- out1_inst  out  32  its word
- take  in  2  instructions consumed this cycle (0, 1 or 2)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: queue empty (count=0, head=tail=0), all slot masks 0, exp_pc=RESET_PC.
- Outputs after reset: out0_valid=out1_valid=0, fetch_ready=1. All out*_pc and out*_inst are 0 whenever the matching valid is 0.
- Entry contents: {pc[31:3], inst[63:0], mask[1:0]}. mask[k]=1 means slot k has not been consumed yet.
- fetch_ready = (count != DEPTH). It is driven from registered state only and does not depend on same-cycle take.
- Enqueue fires when fetch_valid & fetch_ready & ~br_e.
  - If fetch_pc[31:3] == exp_pc[31:3]: write the entry at tail with mask = {1'b1, ~exp_pc[2]}; tail++, count++; exp_pc <= {exp_pc[31:3]+1, 3'b000}.
  - Otherwise the packet is accepted and dropped as wrong-path. Queue and exp_pc are unchanged.
- Output selection is combinational from registered state.
  - out0 = lowest set mask slot of the head entry. If the head has none, out0_valid=0.
  - out1 = the other slot of the head if it is also set; otherwise slot0/first set slot of entry head+1, if count ≥ 2.
  - out*_pc = {entry_pc[31:3], slot, 2'b00}.
  - out1_valid implies out0_valid.
- Dequeue:
  - take must not exceed out0_valid+out1_valid. A violation is an assertion failure and the behaviour is undefined.
  - Consumed slots are cleared from their masks.
  - Any entry whose mask becomes 00 is popped: head advances by the number of entries emptied (0, 1 or 2) and count is reduced accordingly.
  - When out0 and out1 come from different entries and take=2, the head is popped and entry head+1 loses its lower slot.
- Enqueue and dequeue in the same cycle: count updates by +1−pops. When the queue is full, the entry slot freed this cycle is not reused until the next cycle.
- Flush: br_e=1 in a cycle means:
  - the queue is emptied (count=0, head=tail, masks cleared);
  - exp_pc <= br_addr;
  - any same-cycle enqueue and take are ignored.
  - The outputs of that cycle still reflect pre-flush state. The consumer ignores them because it sees br_e.
- Wrap-around: head and tail are log2(DEPTH)-bit counters that wrap modulo DEPTH. Full and empty are distinguished by count.
- Reset mid-operation: rst overrides br_e, enqueue and take. The state returns to reset values next cycle.
- Entry storage (inst, pc) has no reset requirement. Masks, pointers, count and exp_pc are reset.

Decomposition:
- Shared package: IQ_ENTRY_WD and the entry field offsets; the packet-to-slot PC formation constant (slot offset 4).
- One sub-module is natural: iq_slot_sel.
  - Purely combinational.
  - Takes head and head+1 masks/data plus count.
  - Produces out0/out1 and per-entry clear masks for a given take.
- inst_queue_ctrl keeps pointers, count, exp_pc and storage.

Test Plan:
- Reset, then offer pc=bfc00000 and bfc00008, take=0 → count=2, out0_pc=bfc00000, out1_pc=bfc00004, fetch_ready=1.
- Fill 4 packets with take=0 → fetch_ready=0 and a 5th offer is not accepted. Then take=2 for one cycle → fetch_ready=1 next cycle, out0_pc=bfc00008.
- br_e with br_addr=bfc00104 and a queue of 3 → next cycle out0_valid=0, count=0.
  - Offer pc=bfc00100 → entry mask=10, out0_pc=bfc00104, out1_valid=0.
  - Offer pc=bfc00040 after that (exp=bfc00108) → dropped, count unchanged.
- Cross-packet pair: head mask=10 (pc bfc00004) and next entry bfc00008, take=2 → head popped, next mask=10, out0_pc=bfc0000c.
- Simultaneous enqueue, take=2 and a full head entry at count=2 → count stays 2. Same-cycle br_e with a valid fetch → count=0 and the packet is discarded.
- Wrap stress: stream 20 sequential packets with random take 0–2 and no stalls on the fetch side → issued PC sequence is strictly bfc00000+4n with no gaps or duplicates.
